piezo_scheduler: RTL
====================

// Module: piezo_scheduler
// PURPOSE
//  Shares the single piezo output between three sound requesters: bomb alarm,
//  key beep and defuse success. Each requester triggers a fixed 4-note pattern.
//  The block arbitrates by fixed priority, sequences the notes and generates
//  the square-wave tone itself. No external clock dividers are used.
//  It sits between the game FSM (the requesters) and the board piezo pin.
// PARAMETERS
//  NOTE_TICKS  250000   clk cycles per note slot (250 ms at 1 MHz clk)
//  PAT0        12'o1234 alarm pattern, {n3,n2,n1,n0}, 3-bit note codes (octal digits)
//  PAT1        12'o0005 beep pattern
//  PAT2        12'o5432 success pattern
// PORTS
//  clk    in   1  system clock, 1 MHz
//  rst    in   1  asynchronous reset, active-high
//  req    in   3  sound requests, level; rising edge triggers a play.
//                 req[0]=alarm (highest priority), req[1]=beep, req[2]=success (lowest)
//  grant  out  3  one-hot owner of the piezo; 0 when idle
//  busy   out  1  high while in PLAY
//  done   out  1  1-cycle pulse when a pattern completes normally
//  pizo   out  1  piezo drive (square wave)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE. grant=0, busy=0, done=0, pizo=0.
//   All counters, pending[2:0] and req_d cleared. Reset asserted mid-play aborts silently.
//  Edge detect: req_d<=req each edge. pending[i] is set when req[i]&~req_d[i].
//   pending[i] is cleared only on the edge that grants channel i.
//   Set wins over clear for other channels on the same edge.
//  Note codes -> half-period HP (clk cycles):
//   0=rest, 1=2272, 2=1912, 3=1516, 4=1275, 5=956, 6=758, 7=638.
//  FSM states: IDLE, PLAY.
//   IDLE: if pending!=0, on the next edge:
//    - grant = lowest-index pending bit;
//    - busy=1; note idx=0, tick=0, tone cnt=0, pizo=0.
//    Latency: req high sampled at edge k -> grant/busy high after edge k+1.
//   PLAY: tick counts 0..NOTE_TICKS-1 and then wraps.
//    - On the wrap, idx increments; tone cnt=0 and pizo=0 at every note boundary.
//    - Tone: cnt counts 0..HP-1; at HP-1, cnt=0 and pizo toggles.
//      Tone period = 2*HP cycles.
//    - Rest note: pizo held 0 and cnt held 0.
//    - At idx==3 && tick==NOTE_TICKS-1, on the next edge: state=IDLE, grant=0,
//      busy=0, pizo=0, done=1 for exactly one cycle.
//   Total play length = 4*NOTE_TICKS cycles.
//  Back-to-back: a request still pending at done is granted on the following
//   edge, so there is 1 idle cycle between plays.
//  Re-trigger: a rising edge on the owner's own req during PLAY sets its pending
//   bit. The pattern replays after completion (or is superseded, see CONFIGURATION).
//  Simultaneous rising edges are all latched; they are then served in priority order.
//  Widths: tick counter is $clog2(NOTE_TICKS) bits; tone cnt is 12 bits; idx is 2 bits.
// CONFIGURATION
//  PIEZO_PREEMPT_EN defined:
//   In PLAY, if a pending channel has higher priority than the owner, on the next edge:
//    - grant switches to that channel;
//    - idx/tick/cnt reset to 0, pizo=0;
//    - the preempted channel is dropped (not re-queued);
//    - done is not pulsed for the aborted play.
//  PIEZO_PREEMPT_EN undefined:
//   The owner always plays all 4 notes. Higher requests wait in pending.
// TESTING  (sim with NOTE_TICKS=10000)
//  1. Reset, then a req[1] rising edge -> grant=3'b010 two edges later.
//     pizo toggles every 956 cycles for 10000 cycles, then stays 0 for 30000 cycles.
//     done pulses once at cycle 40000 after grant.
//  2. req=3'b111 on the same edge -> served as alarm, beep, success in turn.
//     grant=001, then 010, then 100; 3 done pulses; 1 idle cycle between plays.
//  3. Alarm pattern: pizo half-periods measure 1275, 1516, 1912, 2272 in that order.
//     pizo=0 at each note boundary.
//  4. Preempt: req[2] playing; at tick 5000 of note 1, pulse req[0].
//     Macro on: grant=001 on the next edge; no done for req[2]; req[2] not replayed.
//     Macro off: req[2] completes with done, then alarm plays.
//  5. Assert rst at tick 3000 of note 2 during PLAY.
//     -> grant/busy/pizo/done=0 immediately (async); pending=0.
//     No play after release until a new rising edge on req.
//  6. Hold req[0] high through a full play -> plays exactly once (edge-triggered).
//     Drop req[0] and raise it again -> plays once more.

Source files
------------

// File: rtl/piezo_scheduler.sv
// piezo_scheduler: shares one piezo pin between three sound requesters
// (alarm, beep, success). Rising edges on req latch a pending bit, the
// lowest-index pending channel is granted, and its fixed 4-note pattern is
// played as a square wave generated from clk (no external dividers).
// Optional feature macro: PIEZO_PREEMPT_EN -- a higher-priority pending
// request aborts the current play and takes the piezo immediately.
module piezo_scheduler #(
  parameter int          NOTE_TICKS = 250000,
  parameter logic [11:0] PAT0       = 12'o1234,
  parameter logic [11:0] PAT1       = 12'o0005,
  parameter logic [11:0] PAT2       = 12'o5432
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       busy,
  output logic       done,
  output logic       pizo
);

  localparam int TW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_ONE  = 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(NOTE_TICKS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic          done_q, done_d;
  logic          pizo_q, pizo_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    req_q;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [11:0]   cnt_q, cnt_d;

  logic [2:0]  rise;
  logic [2:0]  pick;
  logic [2:0]  clr;
  logic [11:0] pat_sel;
  logic [2:0]  code;
  logic [11:0] hp;
  logic        tick_last;
  logic        preempt;

  // Request edge detect and fixed-priority pick of the lowest pending index.
  always_comb begin
    rise    = req & ~req_q;
    pick    = 3'b000;
    pick[0] = pend_q[0];
    pick[1] = pend_q[1] & ~pend_q[0];
    pick[2] = pend_q[2] & ~pend_q[1] & ~pend_q[0];
  end

  // Current note code of the owner's pattern and its tone half-period.
  always_comb begin
    pat_sel = PAT2;
    if (grant_q[0])      pat_sel = PAT0;
    else if (grant_q[1]) pat_sel = PAT1;
    code = pat_sel[2:0];
    case (idx_q)
      2'd0:    code = pat_sel[2:0];
      2'd1:    code = pat_sel[5:3];
      2'd2:    code = pat_sel[8:6];
      default: code = pat_sel[11:9];
    endcase
    case (code)
      3'd1:    hp = 12'd2272;
      3'd2:    hp = 12'd1912;
      3'd3:    hp = 12'd1516;
      3'd4:    hp = 12'd1275;
      3'd5:    hp = 12'd956;
      3'd6:    hp = 12'd758;
      3'd7:    hp = 12'd638;
      default: hp = 12'd0;
    endcase
    tick_last = (tick_q == TICK_LAST);
  end

  // Preemption: any pending channel below the owner's index outranks it.
  // grant_q is one-hot in PLAY, so grant_q-1 masks the higher-priority bits.
  always_comb begin
`ifdef PIEZO_PREEMPT_EN
    preempt = (state_q == S_PLAY) && |(pend_q & (grant_q - 3'd1));
`else
    preempt = 1'b0;
`endif
  end

  // Arbitration, note sequencing and tone generation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    pizo_d  = pizo_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    clr     = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d = S_PLAY;
          grant_d = pick;
          clr     = pick;
          idx_d   = 2'd0;
          tick_d  = '0;
          cnt_d   = 12'd0;
          pizo_d  = 1'b0;
        end
      end
      default: begin
        if (preempt) begin
          // Aborted owner is dropped silently: no done, not re-queued.
          grant_d = pick;
          clr     = pick;
          idx_d   = 2'd0;
          tick_d  = '0;
          cnt_d   = 12'd0;
          pizo_d  = 1'b0;
        end else if (tick_last) begin
          tick_d = '0;
          cnt_d  = 12'd0;
          pizo_d = 1'b0;
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
            grant_d = 3'b000;
            done_d  = 1'b1;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
          if (hp == 12'd0) begin
            // Rest: silent and the tone counter parked.
            cnt_d  = 12'd0;
            pizo_d = 1'b0;
          end else if (cnt_q == hp - 12'd1) begin
            cnt_d  = 12'd0;
            pizo_d = ~pizo_q;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
    endcase
    // New edges win over the grant clear of the same cycle.
    pend_d = (pend_q & ~clr) | rise;
  end

  // State registers; reset aborts any play without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      done_q  <= 1'b0;
      pizo_q  <= 1'b0;
      pend_q  <= 3'b000;
      req_q   <= 3'b000;
      idx_q   <= 2'd0;
      tick_q  <= '0;
      cnt_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      pizo_q  <= pizo_d;
      pend_q  <= pend_d;
      req_q   <= req;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == S_PLAY);
  assign done  = done_q;
  assign pizo  = pizo_q;

endmodule
